// File: rtl/regfile_mem_pkg.sv
// Shared definitions for the A/D/M register file and memory unit:
// state encoding, address map defaults and configuration checks.
package regfile_mem_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StIoWait
  } state_e;

  localparam int unsigned ADDR_W_DEFAULT  = 13;
  localparam logic [12:0] IO_BASE_DEFAULT = 13'h1800;

  // Value returned on an I/O timeout; sliced to the data width at use.
  localparam int unsigned MAX_DATA_W              = 64;
  localparam logic [MAX_DATA_W-1:0] ERR_WORD      = '1;

  function automatic bit cfg_ok(input int unsigned data_w, input int unsigned addr_w,
                                input int unsigned depth, input int unsigned io_base,
                                input int unsigned io_timeout);
    return (data_w >= addr_w) && (data_w <= MAX_DATA_W) && (addr_w < 32) &&
           (depth >= 2) && (depth <= io_base) && (io_base < (32'd1 << addr_w)) &&
           (io_timeout >= 1) && (io_timeout <= 65536);
  endfunction

  function automatic int unsigned ram_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mem_ram.sv
// Single-port RAM: synchronous write, registered read. Contents are not reset.
module regfile_mem_ram
  import regfile_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 6144,
  parameter int unsigned AW     = ram_aw(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_mem.sv
// A and D registers plus the M port: RAM, an unmapped hole that reads as zero,
// and a memory-mapped I/O window behind a req/ack handshake with timeout.
module regfile_mem
  import regfile_mem_pkg::*;
#(
  parameter int unsigned         DATA_W     = 16,
  parameter int unsigned         ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned         DEPTH      = 6144,
  parameter logic [ADDR_W-1:0]   IO_BASE    = ADDR_W'(IO_BASE_DEFAULT),
  parameter int unsigned         IO_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_addr_sel,
  input  logic              i_reg_a_en,
  input  logic              i_reg_d_en,
  input  logic              i_a_inc,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  output logic              o_busy,
  output logic              o_mem_ready,
  output logic              o_mem_err,
  output logic [DATA_W-1:0] o_reg_a_out,
  output logic [DATA_W-1:0] o_reg_d_out,
  output logic [DATA_W-1:0] o_reg_m_out,
  output logic              o_io_req,
  output logic              o_io_we,
  output logic [ADDR_W-1:0] o_io_addr,
  output logic [DATA_W-1:0] o_io_wdata,
  input  logic [DATA_W-1:0] i_io_rdata,
  input  logic              i_io_ack
);

  localparam int unsigned RAM_AW   = ram_aw(DEPTH);
  localparam logic [15:0] CNT_LAST = 16'(IO_TIMEOUT - 1);

  if (!cfg_ok(DATA_W, ADDR_W, DEPTH, int'(IO_BASE), IO_TIMEOUT)) begin : g_bad_cfg
    $error("regfile_mem: inconsistent DATA_W/ADDR_W/DEPTH/IO_BASE/IO_TIMEOUT");
  end

  state_e              r_state;
  logic [15:0]         r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic [DATA_W-1:0]   r_m;
  logic                r_m_from_ram;
  logic                r_mem_ready;
  logic                r_mem_err;
  logic                r_io_req;
  logic                r_io_we;
  logic [ADDR_W-1:0]   r_io_addr;
  logic [DATA_W-1:0]   r_io_wdata;

  logic [ADDR_W-1:0]   w_ea;
  logic                w_in_ram;
  logic                w_in_io;
  logic                w_accept;
  logic                w_ram_we;
  logic                w_ram_re;
  logic [DATA_W-1:0]   w_ram_rdata;

  // A is taken before any same-cycle load or increment.
  assign w_ea     = i_addr_sel ? r_a[ADDR_W-1:0] : i_addr;
  assign w_in_ram = w_ea < ADDR_W'(DEPTH);
  assign w_in_io  = w_ea >= IO_BASE;
  assign w_accept = i_mem_req && (r_state == StIdle);
  assign w_ram_we = w_accept && i_mem_we && w_in_ram;
  assign w_ram_re = w_accept && !i_mem_we && w_in_ram;

  regfile_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ea[RAM_AW-1:0]),
    .i_wdata (i_data_in),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_a          <= '0;
      r_d          <= '0;
      r_m          <= '0;
      r_m_from_ram <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_mem_err    <= 1'b0;
      r_io_req     <= 1'b0;
      r_io_we      <= 1'b0;
      r_io_addr    <= '0;
      r_io_wdata   <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      r_mem_err   <= 1'b0;

      if (i_reg_a_en) begin
        r_a <= i_data_in;
      end else if (w_accept && i_a_inc) begin
        r_a <= r_a + DATA_W'(1);
      end
      if (i_reg_d_en) begin
        r_d <= i_data_in;
      end

      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_in_io) begin
              r_state    <= StIoWait;
              r_cnt      <= '0;
              r_io_req   <= 1'b1;
              r_io_we    <= i_mem_we;
              r_io_addr  <= w_ea;
              r_io_wdata <= i_data_in;
            end else begin
              // RAM reads are served straight from the RAM output register.
              r_mem_ready  <= 1'b1;
              r_m_from_ram <= !i_mem_we && w_in_ram;
              r_m          <= i_mem_we ? i_data_in : '0;
            end
          end
        end
        StIoWait: begin
          if (i_io_ack) begin
            r_m          <= r_io_we ? r_io_wdata : i_io_rdata;
            r_m_from_ram <= 1'b0;
            r_mem_ready  <= 1'b1;
            r_io_req     <= 1'b0;
            r_state      <= StIdle;
          end else if (r_cnt == CNT_LAST) begin
            r_m          <= ERR_WORD[DATA_W-1:0];
            r_m_from_ram <= 1'b0;
            r_mem_ready  <= 1'b1;
            r_mem_err    <= 1'b1;
            r_io_req     <= 1'b0;
            r_state      <= StIdle;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = r_io_req;
  assign o_mem_ready = r_mem_ready;
  assign o_mem_err   = r_mem_err;
  assign o_reg_a_out = r_a;
  assign o_reg_d_out = r_d;
  assign o_reg_m_out = r_m_from_ram ? w_ram_rdata : r_m;
  assign o_io_req    = r_io_req;
  assign o_io_we     = r_io_we;
  assign o_io_addr   = r_io_addr;
  assign o_io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_regfile_mem.sv
// Bench for regfile_mem: directed vectors, expected M results queued at issue
// and checked by a monitor whenever mem_ready is seen.
module tb_regfile_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] addr = '0;
  logic        addr_sel = 1'b0;
  logic        reg_a_en = 1'b0;
  logic        reg_d_en = 1'b0;
  logic        a_inc = 1'b0;
  logic [15:0] data_in = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] io_rdata = '0;
  logic        io_ack = 1'b0;

  logic        o_busy, o_mem_ready, o_mem_err, o_io_req, o_io_we;
  logic [15:0] o_reg_a_out, o_reg_d_out, o_reg_m_out, o_io_wdata;
  logic [12:0] o_io_addr;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  regfile_mem #(
    .DATA_W     (16),
    .ADDR_W     (13),
    .DEPTH      (4096),
    .IO_BASE    (13'h1800),
    .IO_TIMEOUT (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_addr      (addr),
    .i_addr_sel  (addr_sel),
    .i_reg_a_en  (reg_a_en),
    .i_reg_d_en  (reg_d_en),
    .i_a_inc     (a_inc),
    .i_data_in   (data_in),
    .i_mem_req   (mem_req),
    .i_mem_we    (mem_we),
    .o_busy      (o_busy),
    .o_mem_ready (o_mem_ready),
    .o_mem_err   (o_mem_err),
    .o_reg_a_out (o_reg_a_out),
    .o_reg_d_out (o_reg_d_out),
    .o_reg_m_out (o_reg_m_out),
    .o_io_req    (o_io_req),
    .o_io_we     (o_io_we),
    .o_io_addr   (o_io_addr),
    .o_io_wdata  (o_io_wdata),
    .i_io_rdata  (io_rdata),
    .i_io_ack    (io_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every mem_ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && o_mem_ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: got mem_ready=1 m=%h expected no pending access",
                 o_reg_m_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_reg_m_out !== e.data || o_mem_err !== e.err) begin
          n_err++;
          $display("FAIL m_result: got m=%h err=%b expected m=%h err=%b",
                   o_reg_m_out, o_mem_err, e.data, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] v);
    reg_a_en = 1'b1;
    data_in  = v;
    tick();
    reg_a_en = 1'b0;
  endtask

  // One RAM/hole access; mem_ready must be up in the cycle after accept.
  task automatic acc(input logic we, input logic sel, input logic inc, input logic [12:0] a,
                     input logic [15:0] d, input logic [15:0] exp_m, input string nm);
    mem_req  = 1'b1;
    mem_we   = we;
    addr_sel = sel;
    a_inc    = inc;
    addr     = a;
    data_in  = d;
    q.push_back(exp_t'{data: exp_m, err: 1'b0});
    tick();
    mem_req = 1'b0;
    a_inc   = 1'b0;
    @(negedge clk);
    check({nm, "_ready"}, {31'd0, o_mem_ready}, 32'd1);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_a", {16'd0, o_reg_a_out}, 32'h0);
    check("rst_d", {16'd0, o_reg_d_out}, 32'h0);
    check("rst_m", {16'd0, o_reg_m_out}, 32'h0);
    check("rst_flags", {27'd0, o_mem_ready, o_mem_err, o_io_req, o_io_we, o_busy}, 32'h0);
    check("rst_io_bus", {3'd0, o_io_addr, o_io_wdata}, 32'h0);
    rst_n = 1'b1;
    tick();

    // A/D loads
    load_a(16'h1234);
    reg_d_en = 1'b1;
    data_in  = 16'h5678;
    tick();
    reg_d_en = 1'b0;
    @(negedge clk);
    check("load_a", {16'd0, o_reg_a_out}, 32'h1234);
    check("load_d", {16'd0, o_reg_d_out}, 32'h5678);

    // RAM, back-to-back, read right after write to same address
    acc(1'b1, 1'b0, 1'b0, 13'd2, 16'h2222, 16'h2222, "wr2");
    acc(1'b1, 1'b0, 1'b0, 13'd3, 16'h3333, 16'h3333, "wr3");
    acc(1'b1, 1'b0, 1'b0, 13'd1, 16'h9ABC, 16'h9ABC, "wr1");
    acc(1'b0, 1'b0, 1'b0, 13'd1, 16'h0000, 16'h9ABC, "rd1");
    acc(1'b0, 1'b0, 1'b0, 13'd2, 16'h0000, 16'h2222, "rd2");

    // A-addressed streaming
    load_a(16'h0010);
    for (int i = 1; i <= 4; i++) acc(1'b1, 1'b1, 1'b1, 13'd0, 16'(i), 16'(i), "stream_wr");
    check("stream_a_after_wr", {16'd0, o_reg_a_out}, 32'h14);
    load_a(16'h0010);
    for (int i = 1; i <= 4; i++) acc(1'b0, 1'b1, 1'b1, 13'd0, 16'h0, 16'(i), "stream_rd");
    check("stream_a_after_rd", {16'd0, o_reg_a_out}, 32'h14);

    // Load beats increment in the same cycle
    reg_a_en = 1'b1;
    acc(1'b0, 1'b0, 1'b1, 13'd1, 16'h0042, 16'h9ABC, "load_vs_inc");
    reg_a_en = 1'b0;
    check("load_wins", {16'd0, o_reg_a_out}, 32'h42);

    // A wraps
    load_a(16'hFFFF);
    acc(1'b0, 1'b0, 1'b1, 13'd2, 16'h0, 16'h2222, "wrap_rd");
    check("a_wrap", {16'd0, o_reg_a_out}, 32'h0);

    // I/O read, ack in the third waiting cycle; a request while busy is ignored
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    addr     = 13'h1800;
    q.push_back(exp_t'{data: 16'hBEEF, err: 1'b0});
    tick();
    mem_we  = 1'b1;
    addr    = 13'd3;
    data_in = 16'h7777;
    @(negedge clk);
    check("io_c1", {30'd0, o_io_req, o_busy}, 32'h3);
    check("io_rd_addr", {19'd0, o_io_addr}, 32'h1800);
    check("io_rd_we", {31'd0, o_io_we}, 32'h0);
    tick();
    @(negedge clk);
    check("io_c2", {30'd0, o_io_req, o_busy}, 32'h3);
    tick();
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    io_ack   = 1'b1;
    io_rdata = 16'hBEEF;
    @(negedge clk);
    check("io_c3", {30'd0, o_io_req, o_busy}, 32'h3);
    tick();
    io_ack = 1'b0;
    @(negedge clk);
    check("io_rd_done", {29'd0, o_io_req, o_busy, o_mem_ready}, 32'h1);

    // I/O write with no ack -> timeout
    mem_req = 1'b1;
    mem_we  = 1'b1;
    addr    = 13'h1801;
    data_in = 16'h5A5A;
    q.push_back(exp_t'{data: 16'hFFFF, err: 1'b1});
    tick();
    mem_req = 1'b0;
    mem_we  = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("io_wr_bus", {o_io_we, 2'd0, o_io_addr, o_io_wdata}, {1'b1, 2'd0, 13'h1801, 16'h5A5A});
      end
      if (!o_io_req) break;
      n++;
    end
    check("timeout_cycles", n, 32'd16);
    check("timeout_flags", {30'd0, o_mem_ready, o_mem_err}, 32'h3);
    io_ack   = 1'b1;
    io_rdata = 16'h1111;
    tick();
    io_ack = 1'b0;
    @(negedge clk);
    check("late_ack_m", {16'd0, o_reg_m_out}, 32'hFFFF);
    check("late_ack_flags", {30'd0, o_mem_ready, o_busy}, 32'h0);

    // Reset during I/O wait: request dropped, nothing completes
    tick();
    mem_req = 1'b1;
    addr    = 13'h1802;
    tick();
    mem_req = 1'b0;
    @(negedge clk);
    check("pre_rst_io_req", {31'd0, o_io_req}, 32'h1);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_io", {29'd0, o_io_req, o_busy, o_mem_ready}, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("post_rst_idle", {29'd0, o_io_req, o_mem_ready, o_mem_err}, 32'h0);

    // Hole reads as zero; RAM survives reset; ignored busy-time write left addr 3 alone
    acc(1'b0, 1'b0, 1'b0, 13'h17FF, 16'h0, 16'h0000, "hole_rd");
    check("hole_err", {31'd0, o_mem_err}, 32'h0);
    acc(1'b1, 1'b0, 1'b0, 13'h17FE, 16'hABCD, 16'hABCD, "hole_wr");
    acc(1'b0, 1'b0, 1'b0, 13'h17FE, 16'h0, 16'h0000, "hole_rd2");
    acc(1'b0, 1'b0, 1'b0, 13'd3, 16'h0, 16'h3333, "rd3_kept");

    repeat (3) tick();
    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mem.md
Name: regfile_mem

Overview:
Parametrised successor to the A/D/M memory unit. It holds the A and D registers and a synchronous RAM, and adds memory-mapped I/O behind a req/ack handshake with timeout. The M address is selectable between an external address and register A, with optional A post-increment. It sits between the CPU datapath and RAM/peripherals; the CPU issues accesses with mem_req and waits for mem_ready.

Parameters:
DATA_W, 16, width of A, D, M and data buses
ADDR_W, 13, address width
DEPTH, 6144, RAM words; must be <= IO_BASE
IO_BASE, 13'h1800, first address routed to the I/O port; IO_BASE..2**ADDR_W-1 is I/O
IO_TIMEOUT, 16, max cycles waiting for io_ack before error

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
addr  in  ADDR_W  external M address
addr_sel  in  1  0: effective address = addr; 1: effective address = reg_a_out[ADDR_W-1:0]
reg_a_en  in  1  load A from data_in
reg_d_en  in  1  load D from data_in
a_inc  in  1  post-increment A on accepted M access
data_in  in  DATA_W  write data for A, D, M
mem_req  in  1  M access request
mem_we  in  1  1: write, 0: read (valid with mem_req)
busy  out  1  high while an I/O access is outstanding
mem_ready  out  1  one-cycle pulse: access complete, reg_m_out valid
mem_err  out  1  pulses with mem_ready on I/O timeout
reg_a_out  out  DATA_W  A register
reg_d_out  out  DATA_W  D register
reg_m_out  out  DATA_W  last completed M data (read data, or written data for writes)
io_req  out  1  I/O request, held until ack or timeout
io_we  out  1  I/O write
io_addr  out  ADDR_W  I/O address (absolute)
io_wdata  out  DATA_W  I/O write data
io_rdata  in  DATA_W  I/O read data, sampled on io_ack
io_ack  in  1  I/O completion

Behaviour:
- Reset (rst_n=0 at an edge): A, D and reg_m_out are 0. mem_ready, mem_err, io_req, io_we and busy are 0. io_addr and io_wdata are 0. State is IDLE and the timeout counter is 0. RAM contents are not cleared.
- A/D loads: register takes data_in at the edge when its enable is high. This is independent of M accesses.
- Effective address (ea): sampled at the accept edge. With addr_sel=1 it uses A's value before any same-cycle load or increment.
- Accept: mem_req=1 while state is IDLE. mem_req while busy is ignored; there is no queue and the requester must hold or retry.
- A post-increment: on accept with a_inc=1, A <= A+1, wrapping mod 2**DATA_W. If reg_a_en=1 in the same cycle, reg_a_en wins.
- State IDLE, RAM region (ea < DEPTH):
  - write: mem[ea] <= data_in at the accept edge.
  - read: the RAM output is registered.
  - mem_ready pulses in the following cycle with reg_m_out = data (1-cycle latency). A read in the cycle after a write to the same ea returns the new data.
- Hole (DEPTH <= ea < IO_BASE): writes are dropped and reads return 0. Same 1-cycle mem_ready, with mem_err=0.
- I/O region (ea >= IO_BASE): at accept, go to IO_WAIT.
  - io_req=1, with io_we, io_addr=ea and io_wdata=data_in registered and held stable.
  - busy=1 from the cycle after accept.
- IO_WAIT, on io_ack=1:
  - reg_m_out <= io_rdata (read) or io_wdata (write).
  - io_req drops at the same edge; mem_ready pulses in the next cycle; return to IDLE.
- IO_WAIT, timeout: the counter increments each IO_WAIT cycle. When it reaches IO_TIMEOUT-1 without an ack:
  - io_req drops and reg_m_out <= all-ones.
  - mem_ready and mem_err pulse in the next cycle; return to IDLE.
  - A late io_ack after this is ignored.
- Back-to-back: a new mem_req is accepted in the same cycle mem_ready is high.
- Reset mid-I/O: io_req drops at the reset edge; no mem_ready is produced.

Decomposition:
- Shared package: state encoding (IDLE, IO_WAIT), IO_BASE default, the all-ones error value and a width-checking function.
- One natural sub-module: regfile_mem_ram, a single-port synchronous-write/registered-read RAM parametrised by DATA_W/DEPTH.

Test Plan:
- Reset, then reg_a_en with data_in=16'h1234, then reg_d_en with 16'h5678 -> reg_a_out=1234 and reg_d_out=5678 one cycle later; all other outputs 0 after reset.
- RAM write 16'h9ABC at addr=1 with addr_sel=0, then read addr=1 -> mem_ready pulses one cycle after each accept; reg_m_out=9ABC. Read addr=2 -> the value written there, not 9ABC.
- A-addressed streaming: A=16'h0010, addr_sel=1, a_inc=1, four writes of 1..4, then A=0x10 and four reads -> reg_m_out sequence 1,2,3,4 and final A=0x14. A=16'hFFFF with a_inc -> A=0.
- I/O read at 13'h1800 with io_ack after 3 cycles and io_rdata=16'hBEEF -> io_req high for those cycles, busy=1, a mem_req issued meanwhile ignored, then reg_m_out=BEEF with mem_ready and mem_err=0.
- I/O write with no io_ack -> io_req drops after IO_TIMEOUT cycles; mem_ready=mem_err=1 and reg_m_out=16'hFFFF; a late ack has no effect.
- rst_n low during IO_WAIT -> io_req=0 at the next edge, no mem_ready. Read at the hole address 13'h17FF (with DEPTH=4096) -> 0 with mem_err=0.
